// File: rtl/ac_motor_drive_core.sv
// Open-loop V/f drive core: ramped frequency, V/f amplitude, dead time, 60-degree
// sector generation with sine weights, and sector/vector-flag to leg-switch mapping.
module ac_motor_drive_core #(
  parameter int ACC_W     = 24,
  parameter int RAMP_DIV  = 256,
  parameter int U_BOOST   = 256,
  parameter int DELAY_MIN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] power,
  input  logic [15:0] mod_delay_umin,
  output logic        modulation,
  output logic [10:0] delay,
  output logic [11:0] frequency,
  output logic [11:0] u_str,
  output logic [2:0]  sector_unsynced,
  output logic [11:0] sine_pos,
  output logic [11:0] sine_neg,
  input  logic [2:0]  sector_synced,
  input  logic        u0,
  input  logic        u1,
  input  logic        u2,
  input  logic        u7,
  output logic        s1,
  output logic        s2,
  output logic        s3
);

  localparam int              CNT_W       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RAMP_DIV - 1);
  localparam logic [10:0]     DELAY_FLOOR = 11'(DELAY_MIN);
  localparam logic [11:0]     U_FLOOR     = 12'(U_BOOST);

  // Sine of 60*i/256 degrees scaled to 4095, evaluated by Taylor series at elaboration.
  function automatic logic [11:0] lut_entry(input int i);
    real x;
    real term;
    real s;
    x    = 3.14159265358979 * real'(i) / 768.0;
    term = x;
    s    = x;
    for (int k = 1; k < 8; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    return 12'($rtoi(4095.0 * s + 0.5));
  endfunction

  // First active vector (s1s2s3) of each sector; the second vector is the next sector's first.
  function automatic logic [2:0] first_vec(input logic [2:0] sec);
    case (sec)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // NOTE: the LUT is pure constants, so it carries no reset and no clock.
  logic [11:0] sine_lut [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [11:0] ENTRY = lut_entry(g);
    assign sine_lut[g] = ENTRY;
  end

  logic             unused_bits;
  logic [11:0]      target;
  logic [CNT_W-1:0] ramp_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic [7:0]       idx;
  logic [2:0]       sec_next;
  logic [2:0]       sw_next;

  assign unused_bits = ^mod_delay_umin[3:0];
  assign target      = modulation ? power : 12'd0;
  assign acc_sum     = {1'b0, acc} + {{(ACC_W - 11){1'b0}}, frequency};
  assign idx         = acc[ACC_W-1 -: 8];
  assign sec_next    = (sector_synced == 3'd5) ? 3'd0 : sector_synced + 3'd1;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      modulation <= 1'b0;
      delay      <= DELAY_FLOOR;
      u_str      <= 12'd0;
    end else begin
      modulation <= mod_delay_umin[15];
      delay      <= (mod_delay_umin[14:4] > DELAY_FLOOR) ? mod_delay_umin[14:4] : DELAY_FLOOR;
      u_str      <= !modulation ? 12'd0 : ((frequency > U_FLOOR) ? frequency : U_FLOOR);
    end
  end

  // The divider idles at 0 while on target, so a new target sees its first step RAMP_DIV cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt  <= '0;
      frequency <= 12'd0;
    end else if (frequency == target) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == CNT_LAST) begin
      ramp_cnt <= '0;
      if (frequency < target && frequency != 12'hFFF) begin
        frequency <= frequency + 12'd1;
      end else if (frequency > target && frequency != 12'd0) begin
        frequency <= frequency - 12'd1;
      end
    end else begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      sector_unsynced <= 3'd0;
      sine_pos        <= 12'd0;
      sine_neg        <= 12'd0;
    end else begin
      acc <= acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        sector_unsynced <= (sector_unsynced == 3'd5) ? 3'd0 : sector_unsynced + 3'd1;
      end
      sine_pos <= sine_lut[idx];
      sine_neg <= sine_lut[8'd255 - idx];
    end
  end

  // Anything other than exactly one flag, or an invalid sector with u1/u2, holds the legs.
  always_comb begin
    // NOTE: default first so every path assigns sw_next and no latch is inferred.
    sw_next = {s1, s2, s3};
    case ({u0, u1, u2, u7})
      4'b1000: sw_next = 3'b000;
      4'b0100: if (sector_synced < 3'd6) sw_next = first_vec(sector_synced);
      4'b0010: if (sector_synced < 3'd6) sw_next = first_vec(sec_next);
      4'b0001: sw_next = 3'b111;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, s3} <= 3'b000;
    end else begin
      {s1, s2, s3} <= sw_next;
    end
  end

endmodule

// File: tb/tb_ac_motor_drive_core.sv
// Self-checking bench for ac_motor_drive_core: switch-mapping vector table plus
// directed ramp, dead-time, sector/sine and reset sequences.
module tb_ac_motor_drive_core;

  localparam int RAMP_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] power;
  logic [15:0] mod_delay_umin;
  logic        modulation;
  logic [10:0] delay;
  logic [11:0] frequency;
  logic [11:0] u_str;
  logic [2:0]  sector_unsynced;
  logic [11:0] sine_pos;
  logic [11:0] sine_neg;
  logic [2:0]  sector_synced;
  logic        u0, u1, u2, u7;
  logic        s1, s2, s3;

  ac_motor_drive_core #(
    .ACC_W(24), .RAMP_DIV(RAMP_DIV), .U_BOOST(256), .DELAY_MIN(16)
  ) dut (
    .clk(clk), .reset(reset), .power(power), .mod_delay_umin(mod_delay_umin),
    .modulation(modulation), .delay(delay), .frequency(frequency), .u_str(u_str),
    .sector_unsynced(sector_unsynced), .sine_pos(sine_pos), .sine_neg(sine_neg),
    .sector_synced(sector_synced), .u0(u0), .u1(u1), .u2(u2), .u7(u7),
    .s1(s1), .s2(s2), .s3(s3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] sector;
    logic [3:0] flags;   // {u0, u1, u2, u7}
    logic [2:0] exp_s;
  } sw_vec_t;

  sw_vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int lut_ref(input int i);
    return $rtoi(4095.0 * $sin(3.14159265358979 * real'(i) / 768.0) + 0.5);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_modulation"}, 32'(modulation), 0);
    check({tag, "_delay"}, 32'(delay), 16);
    check({tag, "_frequency"}, 32'(frequency), 0);
    check({tag, "_u_str"}, 32'(u_str), 0);
    check({tag, "_sector"}, 32'(sector_unsynced), 0);
    check({tag, "_sine_pos"}, 32'(sine_pos), 0);
    check({tag, "_sine_neg"}, 32'(sine_neg), 0);
    check({tag, "_s"}, 32'({s1, s2, s3}), 0);
  endtask

  initial begin
    logic [2:0]  a_pat [6];
    logic [11:0] prev_f;
    logic [2:0]  prev_sec;
    logic [11:0] pp, pn;
    logic [11:0] hold_pos, hold_neg;
    logic [2:0]  hold_sec;
    int n, first_step, ustr_err, step_err;
    int changes, since, pos_drops, neg_rises;
    bit skip;

    // Hand-derived first-vector patterns s1s2s3 per sector.
    a_pat = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    for (int s = 0; s < 6; s++) begin
      vecs.push_back('{3'(s), 4'b1000, 3'b000});
      vecs.push_back('{3'(s), 4'b0100, a_pat[s]});
      vecs.push_back('{3'(s), 4'b0010, a_pat[(s + 1) % 6]});
      vecs.push_back('{3'(s), 4'b0001, 3'b111});
    end
    vecs.push_back('{3'd2, 4'b0010, 3'b011});
    vecs.push_back('{3'd2, 4'b0000, 3'b011});
    vecs.push_back('{3'd2, 4'b0110, 3'b011});
    vecs.push_back('{3'd7, 4'b0100, 3'b011});
    vecs.push_back('{3'd1, 4'b0100, 3'b110});
    vecs.push_back('{3'd6, 4'b1001, 3'b110});
    vecs.push_back('{3'd7, 4'b0010, 3'b110});
    vecs.push_back('{3'd6, 4'b0100, 3'b110});

    reset = 1'b1;
    power = 12'd0;
    mod_delay_umin = 16'h0000;
    sector_synced = 3'd0;
    {u0, u1, u2, u7} = 4'b0000;
    tick;
    tick;
    check_reset("por");
    reset = 1'b0;

    foreach (vecs[i]) begin
      sector_synced = vecs[i].sector;
      {u0, u1, u2, u7} = vecs[i].flags;
      tick;
      check($sformatf("sw_%0d_sec%0d_flags%b", i, vecs[i].sector, vecs[i].flags),
            32'({s1, s2, s3}), 32'(vecs[i].exp_s));
    end
    {u0, u1, u2, u7} = 4'b0000;

    // Full ramp to 4095.
    power = 12'd4095;
    mod_delay_umin = 16'h8000;
    tick;
    check("mod_on", 32'(modulation), 1);
    check("delay_floor_zero", 32'(delay), 16);
    check("u_str_before_mod", 32'(u_str), 0);
    prev_f = frequency;
    n = 0;
    first_step = -1;
    ustr_err = 0;
    step_err = 0;
    while (frequency != 12'd4095 && n < 4095 * RAMP_DIV + 64) begin
      tick;
      n++;
      if (int'(u_str) != ((prev_f > 12'd256) ? int'(prev_f) : 256)) ustr_err++;
      if (frequency != prev_f && frequency != prev_f + 12'd1) step_err++;
      if (frequency == 12'd1 && prev_f == 12'd0) first_step = n;
      prev_f = frequency;
    end
    check("first_step_latency", 32'(first_step), RAMP_DIV);
    check("ramp_full_cycles", 32'(n), 4095 * RAMP_DIV);
    check("u_str_tracking_errors", 32'(ustr_err), 0);
    check("freq_step_errors", 32'(step_err), 0);
    repeat (10) tick;
    check("freq_saturated", 32'(frequency), 4095);
    check("u_str_full", 32'(u_str), 4095);

    mod_delay_umin = 16'h8640;
    tick;
    check("delay_100", 32'(delay), 100);
    mod_delay_umin = 16'h8050;
    tick;
    check("delay_floor_5", 32'(delay), 16);
    check("mod_still_on", 32'(modulation), 1);
    mod_delay_umin = 16'h8000;

    // Sector sequence and sine monotonicity at frequency 4095.
    prev_sec = sector_unsynced;
    pp = sine_pos;
    pn = sine_neg;
    changes = 0;
    since = 0;
    pos_drops = 0;
    neg_rises = 0;
    skip = 1'b0;
    for (int cyc = 0; cyc < 30000 && changes < 7; cyc++) begin
      tick;
      since++;
      if (skip) begin
        check("sine_pos_sector_start", 32'(sine_pos), 0);
        check_near("sine_neg_sector_start", int'(sine_neg), lut_ref(255), 1);
        skip = 1'b0;
      end else if (changes > 0) begin
        if (sine_pos < pp) pos_drops++;
        if (sine_neg > pn) neg_rises++;
      end
      if (sector_unsynced != prev_sec) begin
        check("sector_sequence", 32'(sector_unsynced), 32'((int'(prev_sec) + 1) % 6));
        check_near("sine_pos_sector_end", int'(sine_pos), lut_ref(255), 1);
        if (changes > 0) check_near("sector_period", since, 4097, 1);
        changes++;
        since = 0;
        prev_sec = sector_unsynced;
        skip = 1'b1;
      end
      pp = sine_pos;
      pn = sine_neg;
    end
    check("sector_changes_seen", 32'(changes), 7);
    check("sine_pos_drops", 32'(pos_drops), 0);
    check("sine_neg_rises", 32'(neg_rises), 0);

    // Reset pulsed mid-ramp with u7 asserted.
    power = 12'd10;
    repeat (30) tick;
    sector_synced = 3'd0;
    u7 = 1'b1;
    tick;
    check("pre_reset_s", 32'({s1, s2, s3}), 7);
    check("ramping_down", 32'(frequency < 12'd4095), 1);
    reset = 1'b1;
    tick;
    check_reset("mid");
    reset = 1'b0;
    u7 = 1'b0;

    // Ramp to 10, then drop modulation and decay to 0.
    n = 0;
    while (frequency != 12'd10 && n < 10 * RAMP_DIV + 20) begin
      tick;
      n++;
    end
    check("reach_10", 32'(frequency), 10);
    repeat (3) tick;
    check("hold_10", 32'(frequency), 10);
    check("u_str_boost", 32'(u_str), 256);
    mod_delay_umin = 16'h0000;
    tick;
    check("mod_off", 32'(modulation), 0);
    tick;
    check("u_str_off", 32'(u_str), 0);
    n = 0;
    while (frequency != 12'd0 && n < 10 * RAMP_DIV + 20) begin
      tick;
      n++;
    end
    check("decay_to_0", 32'(frequency), 0);
    tick;
    hold_sec = sector_unsynced;
    hold_pos = sine_pos;
    hold_neg = sine_neg;
    repeat (20) tick;
    check("freq_stays_0", 32'(frequency), 0);
    check("u_str_stays_0", 32'(u_str), 0);
    check("sector_frozen", 32'(sector_unsynced), 32'(hold_sec));
    check("sine_pos_frozen", 32'(sine_pos), 32'(hold_pos));
    check("sine_neg_frozen", 32'(sine_neg), 32'(hold_neg));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
